// File: rtl/qbus_slave_ctl.sv
// QBUS slave-cycle sequencer: synchronizes SYNC/DIN/DOUT, latches the address,
// turns DATI/DATO(B)/DATIO(B) into internal-bus reads and iWRITE pulses, and generates RPLY.
module qbus_slave_ctl #(
  parameter int RPLY_DELAY = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] bDAL_in,
  input  logic        bBS7,
  input  logic        bSYNC,
  input  logic        bDIN,
  input  logic        bDOUT,
  input  logic        bWTBT,
  output logic [15:0] bDAL_out,
  output logic        bDAL_oe,
  output logic        bRPLY,
  output logic [12:0] iADDR,
  output logic        iBS7,
  input  logic        iREAD_MATCH,
  input  logic        iWRITE_MATCH,
  output logic [15:0] iWDATA,
  output logic        iWRITE,
  input  logic [15:0] iRDATA
);

  typedef enum logic [2:0] {IDLE, ADDR, RD, WR, HOLD_IN, HOLD_OUT} state_t;

  localparam logic [3:0] LAST_CNT = 4'(RPLY_DELAY - 1);

  logic [1:0]  syncPipe, dinPipe, doutPipe;
  logic        syncHist;
  logic        sSYNC, sDIN, sDOUT;

  state_t      state, stateNxt;
  logic [12:0] addr, addrNxt;
  logic        bs7, bs7Nxt;
  logic [15:0] wdata, wdataNxt;
  logic        wtbt, wtbtNxt;
  logic [15:0] dalOut, dalOutNxt;
  logic        oe, oeNxt;
  logic        rply, rplyNxt;
  logic [3:0]  cnt, cntNxt;

  // SYNC stages reset to 1 along with the history flop: a SYNC still high at
  // reset release then never looks like a fresh rising edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      syncPipe <= 2'b11;
      dinPipe  <= 2'b00;
      doutPipe <= 2'b00;
      syncHist <= 1'b1;
    end else begin
      syncPipe <= {syncPipe[0], bSYNC};
      dinPipe  <= {dinPipe[0], bDIN};
      doutPipe <= {doutPipe[0], bDOUT};
      syncHist <= sSYNC;
    end
  end

  assign sSYNC = syncPipe[1];
  assign sDIN  = dinPipe[1];
  assign sDOUT = doutPipe[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      addr   <= '0;
      bs7    <= 1'b0;
      wdata  <= '0;
      wtbt   <= 1'b0;
      dalOut <= '0;
      oe     <= 1'b0;
      rply   <= 1'b0;
      cnt    <= '0;
    end else begin
      state  <= stateNxt;
      addr   <= addrNxt;
      bs7    <= bs7Nxt;
      wdata  <= wdataNxt;
      wtbt   <= wtbtNxt;
      dalOut <= dalOutNxt;
      oe     <= oeNxt;
      rply   <= rplyNxt;
      cnt    <= cntNxt;
    end
  end

  always_comb begin
    stateNxt  = state;
    addrNxt   = addr;
    bs7Nxt    = bs7;
    wdataNxt  = wdata;
    wtbtNxt   = wtbt;
    dalOutNxt = dalOut;
    oeNxt     = oe;
    rplyNxt   = rply;
    cntNxt    = cnt;
    case (state)
      IDLE: begin
        if (sSYNC && !syncHist) begin
          addrNxt  = bDAL_in[12:0];
          bs7Nxt   = bBS7;
          stateNxt = ADDR;
        end
      end
      ADDR: begin
        // DIN has priority, so DIN+DOUT together never produces a write.
        if (sDIN) begin
          if (iREAD_MATCH) begin
            dalOutNxt = iRDATA;
            oeNxt     = 1'b1;
            cntNxt    = '0;
            stateNxt  = RD;
          end
        end else if (sDOUT && iWRITE_MATCH) begin
          wdataNxt = bDAL_in;
          wtbtNxt  = bWTBT;
          stateNxt = WR;
        end
      end
      RD: begin
        if (cnt == LAST_CNT) begin
          rplyNxt  = 1'b1;
          stateNxt = HOLD_IN;
        end else begin
          cntNxt = cnt + 4'd1;
        end
      end
      WR: begin
        rplyNxt  = 1'b1;
        stateNxt = HOLD_OUT;
      end
      HOLD_IN: begin
        if (!sDIN) begin
          rplyNxt  = 1'b0;
          oeNxt    = 1'b0;
          stateNxt = ADDR;
        end
      end
      HOLD_OUT: begin
        if (!sDOUT) begin
          rplyNxt  = 1'b0;
          stateNxt = ADDR;
        end
      end
      default: stateNxt = IDLE;
    endcase
    if (state != IDLE && !sSYNC) begin
      stateNxt = IDLE;
      rplyNxt  = 1'b0;
      oeNxt    = 1'b0;
    end
  end

  // Byte writes merge the untouched half from the block's current contents.
  always_comb begin
    iWDATA = wdata;
    if (wtbt) begin
      if (addr[0]) iWDATA = {wdata[15:8], iRDATA[7:0]};
      else         iWDATA = {iRDATA[15:8], wdata[7:0]};
    end
  end

  assign iWRITE   = (state == WR);
  assign iBS7     = (state != IDLE) && bs7;
  assign iADDR    = {addr[12:1], 1'b0};
  assign bDAL_out = dalOut;
  assign bDAL_oe  = oe;
  assign bRPLY    = rply;

endmodule
